// File: rtl/regfile_wb_dump.sv
// Write-back register file with two combinational read ports and a sequential
// dump engine that streams every entry out, one per cycle, for inspection.
module regfile_wb_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam bit                BYP_EN   = (BYPASS != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  wr_sel;

  // Entry 0 never gets a write strobe, so it stays at its reset value of zero.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
      if (gi == 0) begin : g_zero
        assign wr_sel[gi] = 1'b0;
      end else begin : g_entry
        assign wr_sel[gi] = we && (waddr == ADDR_W'(gi));
      end
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = wr_sel[i] ? wdata : mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic byp1;
  logic byp2;

  assign byp1 = BYP_EN && we && (waddr == raddr1);
  assign byp2 = BYP_EN && we && (waddr == raddr2);

  always_comb begin
    rdata1 = mem_q[raddr1];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (byp1) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = mem_q[raddr2];
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (byp2) begin
      rdata2 = wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Dump engine
  // ---------------------------------------------------------------------------
  state_t            state_q,      state_d;
  logic [ADDR_W-1:0] cnt_q,        cnt_d;
  logic              dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0] dump_idx_q,   dump_idx_d;
  logic [DATA_W-1:0] dump_data_q,  dump_data_d;
  logic              dump_done_q,  dump_done_d;
  logic [DATA_W-1:0] dump_src;

  // The entry being emitted reflects a write landing on the same edge only
  // when forwarding is enabled; index 0 always comes out as zero.
  always_comb begin
    dump_src = mem_q[cnt_q];
    if (BYP_EN && we && (cnt_q != '0) && (waddr == cnt_q)) begin
      dump_src = wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    dump_done_d  = dump_done_q;

    case (state_q)
      IDLE: begin
        dump_valid_d = 1'b0;
        dump_done_d  = 1'b0;
        if (dump_req) begin
          state_d = DUMP;
          cnt_d   = '0;
        end
      end
      DUMP: begin
        dump_valid_d = 1'b1;
        dump_idx_d   = cnt_q;
        dump_data_d  = dump_src;
        cnt_d        = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        dump_valid_d = 1'b0;
        dump_done_d  = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d      = IDLE;
        dump_valid_d = 1'b0;
        dump_done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      dump_done_q  <= dump_done_d;
    end
  end

  assign dump_busy  = (state_q != IDLE);
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;
  assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_regfile_wb_dump.sv
// Directed bench for regfile_wb_dump: read/write/bypass checks plus a
// scoreboard of expected dump entries popped as the dump port emits them.
module tb_regfile_wb_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        dump_req;
  logic        dump_busy;
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_done;

  regfile_wb_dump #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .dump_req   (dump_req),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          n_entries;
  bit          done_seen;
  bit          found;
  logic [31:0] model [32];
  logic [36:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, dump entries scored.
  task automatic step();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (dump_valid === 1'b1) begin
      n_entries++;
      if (exp_q.size() == 0) begin
        chk("dump_unexpected_entry", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("dump_idx", {27'd0, dump_idx}, {27'd0, e[36:32]});
        chk("dump_data", dump_data, e[31:0]);
        chk("dump_busy_during", {31'd0, dump_busy}, 32'd1);
        $display("[TB] dump entry idx=%0d data=0x%08h", dump_idx, dump_data);
      end
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we = 1'b0;
    if (a != 5'd0) model[a] = d;
    $display("[TB] write reg[%0d]=0x%08h", a, d);
  endtask

  // mode 0: plain dump; mode 1: writes and a stray dump_req injected mid-dump.
  task automatic run_dump(input int mode);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    chk("busy_after_req", {31'd0, dump_busy}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      if (mode == 1 && i == 20) exp_q.push_back({5'(i), 32'hAAAA5555});
      else                      exp_q.push_back({5'(i), model[i]});
    end
    done_seen = 1'b0;
    n_entries = 0;
    for (int k = 1; k <= 40 && !done_seen; k++) begin
      we       = 1'b0;
      dump_req = 1'b0;
      if (mode == 1 && k == 6)  begin we = 1'b1; waddr = 5'd3;  wdata = 32'h33333333; end
      if (mode == 1 && k == 11) dump_req = 1'b1;
      if (mode == 1 && k == 21) begin we = 1'b1; waddr = 5'd20; wdata = 32'hAAAA5555; end
      step();
      if (dump_done === 1'b1) begin
        done_seen = 1'b1;
        chk("busy_low_at_done", {31'd0, dump_busy}, 32'd0);
        chk("valid_low_at_done", {31'd0, dump_valid}, 32'd0);
      end
    end
    we       = 1'b0;
    dump_req = 1'b0;
    if (mode == 1) begin
      model[3]  = 32'h33333333;
      model[20] = 32'hAAAA5555;
    end
    chk("dump_done_seen", {31'd0, done_seen}, 32'd1);
    chk("dump_entry_count", 32'(n_entries), 32'd32);
    chk("dump_queue_empty", 32'(exp_q.size()), 32'd0);
    step();
    chk("done_one_cycle", {31'd0, dump_done}, 32'd0);
    chk("busy_idle_after", {31'd0, dump_busy}, 32'd0);
    step();
    chk("no_restart_valid", {31'd0, dump_valid}, 32'd0);
    chk("no_restart_busy", {31'd0, dump_busy}, 32'd0);
    $display("[TB] dump mode %0d finished, entries=%0d", mode, n_entries);
  endtask

  initial begin
    rst      = 1'b1;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    raddr1   = '0;
    raddr2   = '0;
    dump_req = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("reset_valid", {31'd0, dump_valid}, 32'd0);
    chk("reset_done", {31'd0, dump_done}, 32'd0);
    chk("reset_busy", {31'd0, dump_busy}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      chk("reset_rdata1", rdata1, 32'd0);
      chk("reset_rdata2", rdata2, 32'd0);
    end
    $display("[TB] reset read-back done");

    // Same-cycle write to reg5 is forwarded, then committed
    raddr1 = 5'd5;
    we     = 1'b1;
    waddr  = 5'd5;
    wdata  = 32'hDEADBEEF;
    #1;
    chk("bypass_before_edge", rdata1, 32'hDEADBEEF);
    step();
    we = 1'b0;
    model[5] = 32'hDEADBEEF;
    #1;
    chk("reg5_after_edge", rdata1, 32'hDEADBEEF);
    $display("[TB] write reg[5]=0xdeadbeef bypass rdata1=0x%08h", rdata1);

    // Writes to reg0 are dropped
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    we     = 1'b1;
    waddr  = 5'd0;
    wdata  = 32'h12345678;
    #1;
    chk("reg0_before_edge", rdata1, 32'd0);
    step();
    we = 1'b0;
    #1;
    chk("reg0_after_edge_p1", rdata1, 32'd0);
    chk("reg0_after_edge_p2", rdata2, 32'd0);
    $display("[TB] write reg[0]=0x12345678 discarded");

    // Fill reg[i] = 0x100 + i
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 32; i++) begin
      raddr2 = 5'(i);
      #1;
      chk("fill_readback", rdata2, model[i]);
    end

    run_dump(0);
    run_dump(1);

    raddr1 = 5'd3;
    raddr2 = 5'd20;
    #1;
    chk("reg3_after_dump", rdata1, 32'h33333333);
    chk("reg20_after_dump", rdata2, 32'hAAAA5555);

    // Reset in the middle of a dump
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), model[i]});
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (dump_valid === 1'b1 && dump_idx == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_idx10", {31'd0, found}, 32'd1);
    exp_q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    chk("abort_valid", {31'd0, dump_valid}, 32'd0);
    chk("abort_busy", {31'd0, dump_busy}, 32'd0);
    chk("abort_done", {31'd0, dump_done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_no_done", {31'd0, dump_done}, 32'd0);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(i);
      #1;
      chk("abort_rdata1", rdata1, 32'd0);
      chk("abort_rdata2", rdata2, 32'd0);
    end
    $display("[TB] reset during dump checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
